// File: rtl/pixel_readout_pkg.sv
// rtl/pixel_readout_pkg.sv - shared types and widths for the pixel readout controller
package pixel_readout_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_NUM_PIXELS = 4;
    localparam int SEL_W          = $clog2(DEF_NUM_PIXELS);

    // Wide enough for the longest legal timed phase (expose, up to 65535 cycles).
    localparam int TIMER_W        = 16;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        SELECT,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/pixel_readout_ctrl_phase_timer.sv
// rtl/pixel_readout_ctrl_phase_timer.sv - loadable down-counter with terminal-count flag
module phase_timer
    import pixel_readout_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               tc
);

    logic [TIMER_W-1:0] count;

    // Load with (phase length - 1) on phase entry, count down and park at zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/pixel_readout_ctrl.sv
// rtl/pixel_readout_ctrl.sv - pixel array phase sequencer and bus receiver
module pixel_readout_ctrl
    import pixel_readout_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int NUM_PIXELS     = DEF_NUM_PIXELS,
    parameter int ERASE_CYCLES   = 4,
    parameter int EXPOSE_CYCLES  = 16,
    parameter int CONVERT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              erase,
    output logic              expose,
    output logic              convert,
    output logic              read,
    output logic [DATA_W-1:0] ramp_code,
    output logic [SEL_W-1:0]  px_sel,
    input  logic [DATA_W-1:0] pixel_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]  out_idx,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [TIMER_W-1:0] ERASE_LOAD   = TIMER_W'(ERASE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] EXPOSE_LOAD  = TIMER_W'(EXPOSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CONVERT_LOAD = TIMER_W'(CONVERT_CYCLES - 1);
    localparam logic [SEL_W-1:0]   LAST_IDX     = SEL_W'(NUM_PIXELS - 1);

    state_t              state;
    state_t              next_state;
    logic                timer_load;
    logic [TIMER_W-1:0]  timer_val;
    logic                timer_tc;
    logic [SEL_W-1:0]    idx;
    logic [DATA_W-1:0]   ramp;

    phase_timer u_phase_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)     next_state = ERASE;
            ERASE:   if (timer_tc)  next_state = EXPOSE;
            EXPOSE:  if (timer_tc)  next_state = CONVERT;
            CONVERT: if (timer_tc)  next_state = SELECT;
            SELECT:                 next_state = CAPTURE;
            CAPTURE: if (out_ready) next_state = (idx == LAST_IDX) ? DONE : SELECT;
            DONE:                   next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Reload the shared phase timer on entry to each timed phase.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = ERASE_LOAD;
        case (state)
            IDLE: begin
                timer_load = start;
                timer_val  = ERASE_LOAD;
            end
            ERASE: begin
                timer_load = timer_tc;
                timer_val  = EXPOSE_LOAD;
            end
            EXPOSE: begin
                timer_load = timer_tc;
                timer_val  = CONVERT_LOAD;
            end
            default: begin
                timer_load = 1'b0;
                timer_val  = ERASE_LOAD;
            end
        endcase
    end

    // Decode array strobes and status from the current state.
    always_comb begin
        erase      = 1'b0;
        expose     = 1'b0;
        convert    = 1'b0;
        read       = 1'b0;
        px_sel     = '0;
        frame_done = 1'b0;
        busy       = (state != IDLE);
        case (state)
            ERASE:   erase      = 1'b1;
            EXPOSE:  expose     = 1'b1;
            CONVERT: convert    = 1'b1;
            SELECT, CAPTURE: begin
                read   = 1'b1;
                px_sel = idx;
            end
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    // Ramp counts from 0 on each convert cycle and is cleared whenever convert is not continuing.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ramp <= '0;
        end else if (state == CONVERT && next_state == CONVERT) begin
            ramp <= ramp + 1'b1;
        end else begin
            ramp <= '0;
        end
    end

    assign ramp_code = ramp;

    // Pixel index and output register: capture on the SELECT->CAPTURE edge, release on accept.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            if (state == CONVERT && timer_tc) begin
                idx <= '0;
            end
            if (state == SELECT) begin
                out_valid <= 1'b1;
                out_data  <= pixel_data;
                out_idx   <= idx;
            end
            if (state == CAPTURE && out_ready) begin
                out_valid <= 1'b0;
                if (idx != LAST_IDX) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// tb/tb_pixel_readout_ctrl.sv - randomized self-checking bench for pixel_readout_ctrl
module tb_pixel_readout_ctrl;

    localparam int E = 2;
    localparam int X = 3;
    localparam int C = 4;
    localparam int N = 4;
    localparam int L = E + X + C + 2 * N + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, start, out_ready;
    logic [7:0] pixel_data;
    logic       erase, expose, convert, read, out_valid, busy, frame_done;
    logic [7:0] ramp_code, out_data;
    logic [1:0] px_sel, out_idx;

    logic       start2, out_ready2;
    logic [7:0] pixel_data2;
    logic       erase2, expose2, convert2, read2, out_valid2, busy2, frame_done2;
    logic [7:0] ramp2, out_data2;
    logic [1:0] px_sel2, out_idx2;

    int total = 0;
    int bad   = 0;

    pixel_readout_ctrl #(
        .DATA_W(8), .NUM_PIXELS(N), .ERASE_CYCLES(E), .EXPOSE_CYCLES(X), .CONVERT_CYCLES(C)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .erase(erase), .expose(expose),
        .convert(convert), .read(read), .ramp_code(ramp_code), .px_sel(px_sel),
        .pixel_data(pixel_data), .out_valid(out_valid), .out_data(out_data),
        .out_idx(out_idx), .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
    );

    pixel_readout_ctrl #(
        .DATA_W(8), .NUM_PIXELS(4), .ERASE_CYCLES(1), .EXPOSE_CYCLES(1), .CONVERT_CYCLES(256)
    ) dut_ramp (
        .clk(clk), .reset_n(reset_n), .start(start2), .erase(erase2), .expose(expose2),
        .convert(convert2), .read(read2), .ramp_code(ramp2), .px_sel(px_sel2),
        .pixel_data(pixel_data2), .out_valid(out_valid2), .out_data(out_data2),
        .out_idx(out_idx2), .out_ready(out_ready2), .busy(busy2), .frame_done(frame_done2)
    );

    function automatic logic [16:0] mk(input int er, input int ex, input int cv, input int rd,
                                       input int sel, input int rmp, input int bz, input int dn,
                                       input int vl);
        return {1'(er), 1'(ex), 1'(cv), 1'(rd), 2'(sel), 8'(rmp), 1'(bz), 1'(dn), 1'(vl)};
    endfunction

    task automatic test_reset();
        logic [53:0] got;
        got = {erase, expose, convert, read, px_sel, ramp_code, busy, frame_done, out_valid, out_data, out_idx,
               erase2, expose2, convert2, read2, ramp2, busy2, frame_done2, out_valid2};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL reset_state got=%h want=0", got);
        end
    endtask

    // rmode: 0 always ready, 1 random ready, 2 five-cycle stall at idx 1
    // dmode: 0 constant A5, 1 random, 2 8'h10+idx in the settle cycle and FF elsewhere
    task automatic run_frame(input int rmode, input int dmode, input int pulse_at, input string name);
        logic        r   [128];
        logic [7:0]  d   [128];
        logic [16:0] ctl [128];
        logic [9:0]  dat [128];
        logic [16:0] got;
        logic [7:0]  cd;
        int          p, c, last, seen_done, dones;
        for (int t = 0; t < 128; t++) begin
            r[t]   = (rmode == 1 && t <= 80) ? 1'($urandom_range(0, 1)) : 1'b1;
            d[t]   = (dmode == 0) ? 8'hA5 : (dmode == 1) ? 8'($urandom) : 8'hFF;
            ctl[t] = '0;
            dat[t] = '0;
        end
        if (rmode == 2) begin
            for (int t = E + X + C + 4; t <= E + X + C + 8; t++) r[t] = 1'b0;
        end
        for (int t = 1; t <= E + X + C; t++) begin
            if (t <= E)          ctl[t] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0);
            else if (t <= E + X) ctl[t] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0);
            else                 ctl[t] = mk(0, 0, 1, 0, 0, t - E - X - 1, 1, 0, 0);
        end
        p = E + X + C + 1;
        for (int i = 0; i < N; i++) begin
            if (dmode == 2) d[p] = 8'h10 + 8'(i);
            cd     = d[p];
            ctl[p] = mk(0, 0, 0, 1, i, 0, 1, 0, 0);
            c      = p + 1;
            ctl[c] = mk(0, 0, 0, 1, i, 0, 1, 0, 1);
            dat[c] = {cd, 2'(i)};
            while (!r[c]) begin
                c++;
                ctl[c] = mk(0, 0, 0, 1, i, 0, 1, 0, 1);
                dat[c] = {cd, 2'(i)};
            end
            p = c + 1;
        end
        ctl[p] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
        last   = p;

        seen_done = 0;
        dones     = 0;
        start     = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= last + 3; t++) begin
            @(negedge clk);
            got = {erase, expose, convert, read, px_sel, ramp_code, busy, frame_done, out_valid};
            total++;
            if (got !== ctl[t]) begin
                bad++;
                $display("FAIL %s ctl t=%0d got=%h want=%h", name, t, got, ctl[t]);
            end
            if (ctl[t][0]) begin
                total++;
                if ({out_data, out_idx} !== dat[t]) begin
                    bad++;
                    $display("FAIL %s data t=%0d got=%h want=%h", name, t, {out_data, out_idx}, dat[t]);
                end
            end
            if (frame_done === 1'b1) begin
                dones++;
                if (seen_done == 0) seen_done = t;
            end
            start      = (t == pulse_at);
            out_ready  = r[t];
            pixel_data = d[t];
        end
        start = 1'b0;
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL %s done_count got=%0d want=1", name, dones);
        end
        if (rmode == 0) begin
            total++;
            if (seen_done != L) begin
                bad++;
                $display("FAIL %s latency got=%0d want=%0d", name, seen_done, L);
            end
        end
    endtask

    task automatic test_reset_mid(input int at, input string name);
        logic [26:0] got;
        start      = 1'b1;
        out_ready  = 1'b0;
        pixel_data = 8'h3C;
        @(posedge clk);
        for (int t = 1; t <= at; t++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s pre_busy got=%b want=1", name, busy);
        end
        reset_n = 1'b0;
        @(negedge clk);
        got = {erase, expose, convert, read, px_sel, ramp_code, busy, frame_done, out_valid, out_data, out_idx};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL %s after_reset got=%h want=0", name, got);
        end
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || frame_done !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s stays_idle t=%0d got=%b%b%b want=000", name, t, busy, frame_done, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t1 = 0;
        int t2 = 0;
        int idle = 0;
        start      = 1'b1;
        out_ready  = 1'b1;
        pixel_data = 8'h55;
        for (int t = 1; t <= 120 && t2 == 0; t++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                if (t1 == 0) t1 = t;
                else         t2 = t;
            end else if (t1 != 0 && busy === 1'b0) begin
                idle++;
            end
        end
        start = 1'b0;
        total++;
        if (t1 != L) begin
            bad++;
            $display("FAIL b2b first_done got=%0d want=%0d", t1, L);
        end
        total++;
        if (t2 - t1 != L + 1) begin
            bad++;
            $display("FAIL b2b gap got=%0d want=%0d", t2 - t1, L + 1);
        end
        total++;
        if (idle != 1) begin
            bad++;
            $display("FAIL b2b idle_cycles got=%0d want=1", idle);
        end
        repeat (L + 5) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b settle_idle got=%b want=0", busy);
        end
    endtask

    task automatic test_ramp_sweep();
        start2 = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 259; t++) begin
            @(negedge clk);
            start2 = 1'b0;
            total++;
            if (t >= 3 && t <= 258) begin
                if (convert2 !== 1'b1 || ramp2 !== 8'(t - 3)) begin
                    bad++;
                    $display("FAIL ramp t=%0d got=%b/%0d want=1/%0d", t, convert2, ramp2, t - 3);
                end
            end else if (t == 259) begin
                if (convert2 !== 1'b0 || ramp2 !== 8'd0 || read2 !== 1'b1) begin
                    bad++;
                    $display("FAIL ramp_exit got=%b/%0d/%b want=0/0/1", convert2, ramp2, read2);
                end
            end else begin
                if (erase2 !== (t == 1) || expose2 !== (t == 2) || ramp2 !== 8'd0) begin
                    bad++;
                    $display("FAIL ramp_pre t=%0d got=%b%b/%0d", t, erase2, expose2, ramp2);
                end
            end
        end
        repeat (20) @(negedge clk);
        total++;
        if (busy2 !== 1'b0 || out_valid2 !== 1'b0 || out_data2 !== 8'h77 || out_idx2 !== 2'd3) begin
            bad++;
            $display("FAIL ramp_finish got=%b%b/%h/%0d want=00/77/3", busy2, out_valid2, out_data2, out_idx2);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        out_ready   = 1'b0;
        pixel_data  = 8'h00;
        start2      = 1'b0;
        out_ready2  = 1'b1;
        pixel_data2 = 8'h77;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);

        run_frame(0, 0, 0, "basic");
        run_frame(0, 2, 0, "index_data");
        run_frame(2, 2, 0, "stall");
        test_reset_mid(E + 2, "rst_expose");
        test_reset_mid(E + X + C + 4, "rst_capture");
        run_frame(0, 1, E + X + 2, "start_busy");
        test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            run_frame(1, 1, (k == 2) ? E + 1 : 0, "random");
        end
        test_ramp_sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_readout_ctrl.md
Name: pixel_readout_ctrl

Overview:
- Sequencer and bus receiver on the controller side of the pixel array interface.
- Drives the array's erase/expose/convert/read phase strobes and the ramp code during conversion.
- Steps the pixel select through all pixels and captures each 8-bit bus value.
- Hands each captured value downstream over a valid/ready handshake, one frame per start request.

Parameters:
- DATA_W, 8, pixel bus and ramp code width.
- NUM_PIXELS, 4, pixels per frame; select width is clog2(NUM_PIXELS) = 2.
- ERASE_CYCLES, 4, cycles erase is held high (legal range 1..255).
- EXPOSE_CYCLES, 16, cycles expose is held high (1..65535).
- CONVERT_CYCLES, 256, cycles convert is held high; the ramp code counts once per cycle (1..2^DATA_W).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  frame request, sampled only in IDLE.
- erase  out  1  array erase strobe.
- expose  out  1  array expose strobe.
- convert  out  1  array convert strobe.
- read  out  1  array read strobe (pixel drives bus).
- ramp_code  out  DATA_W  digital ramp value during convert.
- px_sel  out  2  pixel select to array decoder.
- pixel_data  in  DATA_W  array data bus.
- out_valid  out  1  captured pixel available.
- out_data  out  DATA_W  captured pixel value.
- out_idx  out  2  index of captured pixel.
- out_ready  in  1  downstream accept.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- One clock, synchronous active-low reset.
- reset_n=0 at any edge: state IDLE, all outputs 0 (strobes, ramp_code, px_sel, out_valid, out_data, out_idx, busy, frame_done). This applies mid-frame too; the frame is abandoned and no partial output remains.
- States and transitions:
  - IDLE: leave on start=1 at an edge, go to ERASE.
  - ERASE: erase=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
  - EXPOSE: expose=1 for EXPOSE_CYCLES cycles, then CONVERT.
  - CONVERT: convert=1 for CONVERT_CYCLES cycles. ramp_code=0 in the first CONVERT cycle, +1 per cycle, reaching CONVERT_CYCLES-1 in the last cycle. ramp_code returns to 0 on exit and is 0 outside CONVERT. Then SELECT with idx=0.
  - SELECT: read=1, px_sel=idx for one settle cycle, no capture. Then CAPTURE.
  - CAPTURE: at the entry edge, latch pixel_data into out_data, set out_idx=idx and out_valid=1. Hold read=1 and px_sel stable while waiting. On out_valid&&out_ready at an edge, clear out_valid:
    - if idx<NUM_PIXELS-1: idx+1, go to SELECT;
    - else go to DONE.
  - DONE: frame_done=1 for one cycle, read=0, then IDLE.
- Phase strobes are mutually exclusive (one-hot or all 0).
- out_data and out_idx stay stable while out_valid=1 and are not changed by pixel_data during the stall.
- out_ready=1 in the capture cycle gives a zero-stall transfer, so each pixel costs 2 cycles.
- start while busy is ignored.
- start held high through DONE starts the next frame on the first IDLE edge. IDLE lasts at least 1 cycle between frames.
- Latency with out_ready tied high: start edge to frame_done = ERASE+EXPOSE+CONVERT+2·NUM_PIXELS+1 cycles.
- Phase counters are sized for the largest legal parameter. They reload at each state entry and must not wrap.

Decomposition:
- Package pixel_readout_pkg holds:
  - state enum: IDLE, ERASE, EXPOSE, CONVERT, SELECT, CAPTURE, DONE;
  - DATA_W default and pixel select width localparam.
- One sub-module, phase_timer: loadable down-counter with terminal-count flag. It is shared by the three timed phases; the ramp code comes from a separate up-counter in the top.

Test Plan:
- ERASE=2, EXPOSE=3, CONVERT=4, out_ready=1, pixel_data=8'hA5 → erase 2 cycles, expose 3, convert 4 with ramp_code 0,1,2,3; four outputs A5 with idx 0..3; frame_done 18 cycles after the start edge.
- pixel_data driven as 8'h10+px_sel with a one-cycle model delay, out_ready=1 → out_data 10,11,12,13 in order.
- out_ready=0 for 5 cycles at idx=1, with pixel_data changed to 8'hFF during the stall → out_valid held, out_data/out_idx stable, read=1 and px_sel=1 held; idx 2 follows after accept.
- reset_n=0 for 1 cycle during EXPOSE and again during CAPTURE → next cycle all outputs 0, state IDLE, no frame_done.
- start pulsed during CONVERT → ignored, only one frame_done. start held high continuously → back-to-back frames with exactly one IDLE cycle between them.
- CONVERT_CYCLES=256 → ramp_code sweeps 0..255 without wrap, then 0 in SELECT.
